dma_xfer_engine: RTL and testbench



---
 rtl/dma_xfer_engine.sv | 156 +++++++++++++++
 tb/tb_dma_xfer_engine.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_xfer_engine.sv
// dma_xfer_engine: single-channel byte mover. It reads one byte from the
// source pointer, writes it to the destination pointer, and repeats LEN times.
// Configuration registers are writable only while the engine is idle.
//
// Handshake semantics (both read and write sides): a request is held high,
// with its address/data stable, from the cycle it is raised until a clock
// edge on which ena=1 and the matching ack=1. That edge completes the beat.
// An ack while no request is pending, or while ena=0, is ignored. abort on
// the same edge wins over the ack, and the beat is not counted.
module dma_xfer_engine #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_addr,
  input  logic [7:0]    cfg_wdata,
  input  logic          start,
  input  logic          abort,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_ack,
  input  logic [DW-1:0] rd_data,
  output logic          wr_req,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  input  logic          wr_ack,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] remaining
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [LW-1:0] len_q, len_d;
  logic [1:0]    ctrl_q, ctrl_d;   // bit0 SRC_INC, bit1 DST_INC
  logic [LW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [DW-1:0] data_q, data_d;

  // State and datapath registers; ena=0 is handled by holding every _d at _q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic: config writes in IDLE, transfer sequencing, abort.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    data_d  = data_q;

    if (ena) begin
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_we) begin
            unique case (cfg_addr)
              REG_SRC:  src_d  = AW'(cfg_wdata);
              REG_DST:  dst_d  = AW'(cfg_wdata);
              REG_LEN:  len_d  = LW'(cfg_wdata);
              REG_CTRL: ctrl_d = cfg_wdata[1:0];
              default:  ;
            endcase
          end
          // start samples the registers as they stood before this edge.
          if (start) begin
            if (len_q != '0) begin
              cnt_d   = len_q;
              rptr_d  = src_q;
              wptr_d  = dst_q;
              state_d = ST_READ;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_READ: begin
          if (abort) begin
            state_d = ST_IDLE;
          end else if (rd_ack) begin
            data_d  = rd_data;
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (abort) begin
            state_d = ST_IDLE;
          end else if (wr_ack) begin
            cnt_d   = cnt_q - LW'(1);
            // Pointers wrap modulo 2^AW by plain overflow.
            rptr_d  = rptr_q + AW'(ctrl_q[0]);
            wptr_d  = wptr_q + AW'(ctrl_q[1]);
            state_d = (cnt_q == LW'(1)) ? ST_DONE : ST_READ;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so they clear with reset.
  assign rd_req    = (state_q == ST_READ);
  assign wr_req    = (state_q == ST_WRITE);
  assign busy      = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign done      = (state_q == ST_DONE);
  assign rd_addr   = rptr_q;
  assign wr_addr   = wptr_q;
  assign wr_data   = data_q;
  assign remaining = cnt_q;

endmodule

// File: tb/tb_dma_xfer_engine.sv
// tb_dma_xfer_engine: directed bench with an expected-event queue. The main
// process drives configuration/start and pushes expected bus events; a
// responder drives acks with programmable delay; a monitor pops and compares
// each accepted read, accepted write and done pulse.
module tb_dma_xfer_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       start;
  logic       abort;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic       rd_ack;
  logic [7:0] rd_data;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       busy;
  logic       done;
  logic [7:0] remaining;

  int tests = 0;
  int fails = 0;
  logic [17:0] exp_q[$];
  int rd_delay = 0;
  int wr_delay = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  dma_xfer_engine #(.AW(8), .DW(8), .LW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .start     (start),
    .abort     (abort),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  // clock / memory model
  always #5 clk = ~clk;
  assign rd_data = rd_addr ^ 8'hA5;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] ev(input logic [1:0] k, input logic [7:0] a, input logic [7:0] d);
    return {k, a, d};
  endfunction

  task automatic push_rd(input logic [7:0] a);
    exp_q.push_back(ev(2'd1, a, a ^ 8'hA5));
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] src);
    exp_q.push_back(ev(2'd2, a, src ^ 8'hA5));
  endtask

  task automatic push_done(input logic [7:0] rem);
    exp_q.push_back(ev(2'd3, rem, 8'h00));
  endtask

  task automatic sb_compare(input logic [17:0] got);
    logic [17:0] e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: unexpected event %h with empty queue", got);
    end else begin
      e = exp_q.pop_front();
      check("scoreboard event", 64'(got), 64'(e));
    end
  endtask

  // driver: ack responder (runs after the main driver on each falling edge)
  initial begin
    rd_ack = 1'b0;
    wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        rd_ack = 1'b0; wr_ack = 1'b0; rd_cnt = 0; wr_cnt = 0;
      end else if (!ena) begin
        // Offer acks while frozen; the engine must ignore them.
        rd_ack = rd_req;
        wr_ack = wr_req;
      end else begin
        if (rd_req) begin
          if (rd_cnt >= rd_delay) begin rd_ack = 1'b1; rd_cnt = 0; end
          else begin rd_ack = 1'b0; rd_cnt++; end
        end else begin
          rd_ack = 1'b0; rd_cnt = 0;
        end
        if (wr_req) begin
          if (wr_cnt >= wr_delay) begin wr_ack = 1'b1; wr_cnt = 0; end
          else begin wr_ack = 1'b0; wr_cnt++; end
        end else begin
          wr_ack = 1'b0; wr_cnt = 0;
        end
      end
    end
  end

  // monitor: just before each rising edge, record what that edge will accept
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && ena) begin
        if (rd_req && rd_ack && !abort) sb_compare(ev(2'd1, rd_addr, rd_data));
        if (wr_req && wr_ack && !abort) sb_compare(ev(2'd2, wr_addr, wr_data));
        if (done) sb_compare(ev(2'd3, remaining, 8'h00));
      end
    end
  end

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic configure(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                           input logic [7:0] c);
    cfg_write(2'd0, s);
    cfg_write(2'd1, d);
    cfg_write(2'd2, l);
    cfg_write(2'd3, c);
  endtask

  // Pulse start and follow the transfer until done (bounded).
  task automatic run_xfer(input bit cfg_mid, output int cyc, output bit first_rd,
                          output bit any_req, output int bad);
    logic       p_rd, p_wr;
    logic [7:0] p_ra, p_wa, p_wd;
    cyc = 0; first_rd = 1'b0; any_req = 1'b0; bad = 0;
    p_rd = 1'b0; p_wr = 1'b0; p_ra = '0; p_wa = '0; p_wd = '0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cfg_mid && cyc == 1) begin cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 8'h09; end
      if (cfg_mid && cyc == 2) cfg_we = 1'b0;
      if (cyc == 1) first_rd = rd_req;
      if (rd_req || wr_req) any_req = 1'b1;
      if (rd_req && wr_req) bad++;
      if (rd_req && p_rd && rd_addr != p_ra) bad++;
      if (wr_req && p_wr && (wr_addr != p_wa || wr_data != p_wd)) bad++;
      p_rd = rd_req; p_wr = wr_req; p_ra = rd_addr; p_wa = wr_addr; p_wd = wr_data;
      if (done) break;
    end
  endtask

  // main stimulus
  initial begin
    int  cyc;
    bit  first_rd;
    bit  any_req;
    int  bad;
    bit  seen_done;

    rst_n = 1'b0; ena = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset outputs",
          64'({rd_req, wr_req, busy, done, rd_addr, wr_addr, wr_data, remaining}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: incrementing copy, acks immediate
    configure(8'h10, 8'h80, 8'd3, 8'h03);
    push_rd(8'h10); push_wr(8'h80, 8'h10);
    push_rd(8'h11); push_wr(8'h81, 8'h11);
    push_rd(8'h12); push_wr(8'h82, 8'h12);
    push_done(8'd0);
    run_xfer(1'b0, cyc, first_rd, any_req, bad);
    check("t1 rd_req next cycle", 64'(first_rd), 64'd1);
    check("t1 done cycle", 64'(cyc), 64'd7);
    check("t1 remaining", 64'(remaining), 64'd0);
    check("t1 protocol", 64'(bad), 64'd0);

    // 2: zero length
    cfg_write(2'd2, 8'd0);
    push_done(8'd0);
    run_xfer(1'b0, cyc, first_rd, any_req, bad);
    check("t2 done cycle", 64'(cyc), 64'd1);
    check("t2 no requests", 64'(any_req), 64'd0);

    // 3: source wraps, destination fixed
    configure(8'hFE, 8'h40, 8'd3, 8'h01);
    push_rd(8'hFE); push_wr(8'h40, 8'hFE);
    push_rd(8'hFF); push_wr(8'h40, 8'hFF);
    push_rd(8'h00); push_wr(8'h40, 8'h00);
    push_done(8'd0);
    run_xfer(1'b0, cyc, first_rd, any_req, bad);
    check("t3 done cycle", 64'(cyc), 64'd7);
    check("t3 protocol", 64'(bad), 64'd0);

    // 4: slow acks, config write while busy dropped
    configure(8'h20, 8'h30, 8'd2, 8'h03);
    rd_delay = 3; wr_delay = 2;
    push_rd(8'h20); push_wr(8'h30, 8'h20);
    push_rd(8'h21); push_wr(8'h31, 8'h21);
    push_done(8'd0);
    run_xfer(1'b1, cyc, first_rd, any_req, bad);
    check("t4 done cycle", 64'(cyc), 64'd15);
    check("t4 stable while requesting", 64'(bad), 64'd0);
    push_rd(8'h20); push_wr(8'h30, 8'h20);
    push_rd(8'h21); push_wr(8'h31, 8'h21);
    push_done(8'd0);
    run_xfer(1'b0, cyc, first_rd, any_req, bad);
    check("t4 LEN unchanged by busy write", 64'(cyc), 64'd15);

    // 5: abort with wr_ack on the second write, then full repeat
    rd_delay = 0; wr_delay = 0;
    configure(8'h50, 8'h60, 8'd5, 8'h03);
    push_rd(8'h50); push_wr(8'h60, 8'h50);
    push_rd(8'h51);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("t5 in second write", 64'(wr_req), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5 idle after abort", 64'({busy, rd_req, wr_req, done}), 64'd0);
    check("t5 residual remaining", 64'(remaining), 64'd4);
    seen_done = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("t5 no done after abort", 64'(seen_done), 64'd0);
    for (int b = 0; b < 5; b++) begin
      push_rd(8'h50 + 8'(b));
      push_wr(8'h60 + 8'(b), 8'h50 + 8'(b));
    end
    push_done(8'd0);
    run_xfer(1'b0, cyc, first_rd, any_req, bad);
    check("t5 full repeat cycle", 64'(cyc), 64'd11);

    // 6: freeze mid-READ, then async reset mid-WRITE
    configure(8'h70, 8'h90, 8'd3, 8'h03);
    rd_delay = 2; wr_delay = 3;
    push_rd(8'h70);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ena = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check("t6 frozen", 64'({rd_req, busy, wr_req, rd_addr, remaining}),
            64'({1'b1, 1'b1, 1'b0, 8'h70, 8'd3}));
    end
    ena = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (wr_req) break;
    end
    check("t6 reached write", 64'(wr_req), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6 async reset outputs",
          64'({rd_req, wr_req, busy, done, rd_addr, wr_addr, wr_data, remaining}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("queue drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
